// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU memory stage.
// It accepts one load or store at a time and services it against an internal
// word array after LAT cycles. The completion is a one-cycle response pulse.
// While a request is outstanding, stall holds the pipeline.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   M stage presents a request
//   req_ready   responder idle, request will be accepted this edge
//   req_we      1 = store, 0 = load
//   req_addr    word address
//   req_wdata   store data
//   resp_valid  one-cycle completion pulse
//   resp_we     type of the completing request (1 = store ack)
//   resp_rdata  load data, held until the next load completes
//   stall       req_valid && !resp_valid
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUSY  | request latched, counting down the remaining latency
// RESP  | access done on the entry edge; resp_valid high for this cycle
module dmem_responder #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_we,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              stall
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] CNT_INIT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
   localparam bit         LAT_ONE  = (LAT == 1);

   state_t              state;
   logic [3:0]          cnt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic                accept;
   logic                access;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign stall     = req_valid && !resp_valid;

   // With LAT==1 the access edge is the accept edge itself, so the request
   // fields are used directly; otherwise the latched copies are used.
   always_comb begin
      access    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state == IDLE) begin
         access    = accept && LAT_ONE;
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end else if (state == BUSY) begin
         access = (cnt == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_valid <= 1'b0;
         resp_we    <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= access;
         if (access) begin
            resp_we <= acc_we;
            if (!acc_we)
               resp_rdata <= mem[acc_addr];
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (LAT_ONE) begin
                     state <= RESP;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A store whose commit edge sees rst high is dropped.
   always_ff @(posedge clk) begin
      if (!rst && access && acc_we)
         mem[acc_addr] <= acc_wdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Four instances are used, with LAT = 1, 2, 3 and 4
// (index 0..3). They share clock, reset and request fields, and each has its
// own req_valid.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rv = 4'b0;
   logic        r_we = 1'b0;
   logic [6:0]  r_addr = '0;
   logic [31:0] r_wdata = '0;

   logic        rdy    [4];
   logic        rvalid [4];
   logic        rwe_o  [4];
   logic        stl    [4];
   logic [31:0] rdata  [4];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(r_we),
      .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rvalid[0]),
      .resp_we(rwe_o[0]), .resp_rdata(rdata[0]), .stall(stl[0]));
   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(r_we),
      .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rvalid[1]),
      .resp_we(rwe_o[1]), .resp_rdata(rdata[1]), .stall(stl[1]));
   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(r_we),
      .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rvalid[2]),
      .resp_we(rwe_o[2]), .resp_rdata(rdata[2]), .stall(stl[2]));
   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LAT(4)) u_lat4 (
      .clk(clk), .rst(rst), .req_valid(rv[3]), .req_ready(rdy[3]), .req_we(r_we),
      .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rvalid[3]),
      .resp_we(rwe_o[3]), .resp_rdata(rdata[3]), .stall(stl[3]));

   // Presents one request on instance k and follows it to its response.
   // lat: cycles from the accept edge to the resp_valid cycle (-1 = none within bound)
   // stall_cnt: stall-high cycles before the response cycle
   // busy_rdy: cycles after the accept edge in which req_ready was high
   // acc_cyc: index of the accept edge
   // scramble: perturb the request fields every cycle after the accept
   task automatic do_req(input int k, input logic we, input logic [6:0] addr,
                         input logic [31:0] wd, input bit scramble,
                         output int lat, output int stall_cnt, output bit stall_at_resp,
                         output int busy_rdy, output logic rwe, output logic [31:0] rd,
                         output int acc_cyc, output bit rdy0);
      @(negedge clk);
      rv[k] = 1'b1; r_we = we; r_addr = addr; r_wdata = wd;
      #1;
      rdy0 = rdy[k];
      stall_cnt = stl[k] ? 1 : 0;
      lat = -1; busy_rdy = 0; stall_at_resp = 1'b1; rwe = 1'bx; rd = 'x;
      @(posedge clk);
      acc_cyc = int'($time / 10);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (scramble) begin
            r_addr = 7'h11; r_we = 1'b1; r_wdata = $urandom;
         end
         #1;
         if (rdy[k]) busy_rdy++;
         if (rvalid[k]) begin
            lat = c; stall_at_resp = stl[k]; rwe = rwe_o[k]; rd = rdata[k];
            break;
         end
         if (stl[k]) stall_cnt++;
      end
      rv[k] = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1; rv[1] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (rdy[1] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy[1]); end
      checks++; if (rvalid[1] !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", rvalid[1]); end
      checks++; if (rwe_o[1] !== 1'b0) begin failures++; $display("FAIL reset_resp_we got=%b exp=0", rwe_o[1]); end
      checks++; if (stl[1] !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", stl[1]); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rdata[i] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", i, rdata[i]); end
      end
      @(negedge clk);
      rst = 1'b0; rv[1] = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (rvalid[1]) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL reset_no_resp got=%0d exp=0", seen); end
   endtask

   task automatic test_store_load();
      int lat, sc, br, ac; bit sar, r0; logic w; logic [31:0] d;
      do_req(1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL sl_st_ready got=%b exp=1", r0); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL sl_st_lat got=%0d exp=2", lat); end
      checks++; if (w !== 1'b1) begin failures++; $display("FAIL sl_st_we got=%b exp=1", w); end
      checks++; if (sar !== 1'b0) begin failures++; $display("FAIL sl_st_stall_resp got=%b exp=0", sar); end
      do_req(1, 1'b0, 7'h05, 32'h0, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sl_ld_lat got=%0d exp=2", lat); end
      checks++; if (w !== 1'b0) begin failures++; $display("FAIL sl_ld_we got=%b exp=0", w); end
      checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_ld_data got=%h exp=deadbeef", d); end
      checks++; if (sc !== 2) begin failures++; $display("FAIL sl_ld_stall_cycles got=%0d exp=2", sc); end
   endtask

   task automatic test_back_to_back();
      logic        we_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [6:0]  ad_v [5] = '{7'h00, 7'h7F, 7'h00, 7'h7F, 7'h01};
      logic [31:0] wd_v [5] = '{32'd1, 32'd2, 32'd0, 32'd0, 32'd3};
      logic [31:0] ex_v [5] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd2};
      int lat, sc, br, ac, prev_ac; bit sar, r0; logic w; logic [31:0] d;
      prev_ac = -1;
      for (int i = 0; i < 5; i++) begin
         do_req(0, we_v[i], ad_v[i], wd_v[i], 1'b0, lat, sc, sar, br, w, d, ac, r0);
         checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_lat[%0d] got=%0d exp=1", i, lat); end
         checks++; if (w !== we_v[i]) begin failures++; $display("FAIL b2b_we[%0d] got=%b exp=%b", i, w, we_v[i]); end
         checks++; if (d !== ex_v[i]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, d, ex_v[i]); end
         if (i > 0) begin
            checks++; if (ac - prev_ac !== 2) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=2", i, ac - prev_ac); end
         end
         prev_ac = ac;
      end
   endtask

   task automatic test_instability();
      int lat, sc, br, ac; bit sar, r0; logic w; logic [31:0] d;
      do_req(3, 1'b1, 7'h10, 32'h0BADF00D, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      do_req(3, 1'b1, 7'h11, 32'h11111111, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      do_req(3, 1'b0, 7'h10, 32'h0, 1'b1, lat, sc, sar, br, w, d, ac, r0);
      checks++; if (lat !== 4) begin failures++; $display("FAIL inst_lat got=%0d exp=4", lat); end
      checks++; if (w !== 1'b0) begin failures++; $display("FAIL inst_we got=%b exp=0", w); end
      checks++; if (d !== 32'h0BADF00D) begin failures++; $display("FAIL inst_data got=%h exp=0badf00d", d); end
      checks++; if (br !== 0) begin failures++; $display("FAIL inst_busy_ready got=%0d exp=0", br); end
      checks++; if (sc !== 4) begin failures++; $display("FAIL inst_stall_cycles got=%0d exp=4", sc); end
      do_req(3, 1'b0, 7'h11, 32'h0, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      checks++; if (d !== 32'h11111111) begin failures++; $display("FAIL inst_unchanged got=%h exp=11111111", d); end
   endtask

   task automatic test_reset_mid_store();
      int lat, sc, br, ac, seen; bit sar, r0; logic w; logic [31:0] d;
      do_req(2, 1'b1, 7'h20, 32'hAAAA5555, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      @(negedge clk);
      rv[2] = 1'b1; r_we = 1'b1; r_addr = 7'h20; r_wdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; rv[2] = 1'b0;
      @(negedge clk); #1;
      checks++; if (rvalid[2] !== 1'b0) begin failures++; $display("FAIL rms_resp_on_reset got=%b exp=0", rvalid[2]); end
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (rvalid[2]) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rms_no_resp got=%0d exp=0", seen); end
      do_req(2, 1'b0, 7'h20, 32'h0, 1'b0, lat, sc, sar, br, w, d, ac, r0);
      checks++; if (d !== 32'hAAAA5555) begin failures++; $display("FAIL rms_not_written got=%h exp=aaaa5555", d); end
   endtask

   task automatic test_random();
      logic [31:0] model [8];
      int lat, sc, br, ac, resp; bit sar, r0; logic w, we; logic [31:0] d, wd;
      logic [2:0] a;
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         do_req(2, 1'b1, 7'h40 + 7'(i), model[i], 1'b0, lat, sc, sar, br, w, d, ac, r0);
      end
      resp = 0;
      for (int i = 0; i < 10; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         do_req(2, we, 7'h40 + 7'(a), wd, 1'b0, lat, sc, sar, br, w, d, ac, r0);
         if (lat > 0) resp++;
         checks++; if (lat !== 3) begin failures++; $display("FAIL rnd_lat[%0d] got=%0d exp=3", i, lat); end
         checks++; if (sc !== 3) begin failures++; $display("FAIL rnd_stall_cycles[%0d] got=%0d exp=3", i, sc); end
         checks++; if (sar !== 1'b0) begin failures++; $display("FAIL rnd_stall_resp[%0d] got=%b exp=0", i, sar); end
         checks++; if (w !== we) begin failures++; $display("FAIL rnd_we[%0d] got=%b exp=%b", i, w, we); end
         if (we) begin
            model[a] = wd;
         end else begin
            checks++; if (d !== model[a]) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, d, model[a]); end
         end
      end
      checks++; if (resp !== 10) begin failures++; $display("FAIL rnd_resp_count got=%0d exp=10", resp); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_instability();
      test_reset_mid_store();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
